// File: rtl/swa_pkg.sv
// swa_pkg: shared constants and output-register state type for serial_word_assembler
package swa_pkg;
  localparam int SWA_DEFAULT_WIDTH = 8;
  localparam int SWA_COUNT_W = 16;
  typedef enum logic {SWA_EMPTY = 1'b0, SWA_FULL = 1'b1} swa_state_t;
endpackage

// File: rtl/swa_out_reg.sv
// swa_out_reg: WIDTH-bit holding register with valid/ready output handshake
module swa_out_reg
  import swa_pkg::*;
#(
  parameter int WIDTH = SWA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             word_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid
);
  swa_state_t state_q, state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= SWA_EMPTY;
    else state_q <= state_d;
  // a load in the same cycle as a consume keeps FULL, so back-to-back words have no bubble
  always_comb
    state_d = load ? SWA_FULL : (state_q == SWA_FULL && word_ready) ? SWA_EMPTY : state_q;
  always_comb word_valid = state_q == SWA_FULL;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) word_out <= '0;
    else if (load) word_out <= load_data;
endmodule

// File: rtl/serial_word_assembler.sv
// serial_word_assembler: LSB-first serial-to-parallel packer with handshaked word output
// Optional delivered-word counter port enabled by defining SWA_WORD_COUNT_EN.
module serial_word_assembler
  import swa_pkg::*;
#(
  parameter int WIDTH = SWA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready
`ifdef SWA_WORD_COUNT_EN
  ,
  output logic [SWA_COUNT_W-1:0] word_count
`endif
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shift;
  logic at_last, bit_xfer, complete;
  assign at_last   = bit_cnt == LAST;
  // only the final bit of a word can stall; flush blocks acceptance so it wins over completion
  assign bit_ready = !flush && !(at_last && word_valid && !word_ready);
  assign bit_xfer  = bit_valid && bit_ready;
  assign complete  = bit_xfer && at_last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bit_cnt <= '0;
      shift   <= '0;
    end else if (flush) begin
      bit_cnt <= '0;
      shift   <= '0;
    end else if (bit_xfer) begin
      shift[bit_cnt] <= bit_in;
      bit_cnt        <= at_last ? '0 : bit_cnt + CNT_W'(1);
    end
  swa_out_reg #(.WIDTH(WIDTH)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (complete),
    .load_data ({bit_in, shift[WIDTH-2:0]}),
    .word_ready(word_ready),
    .word_out  (word_out),
    .word_valid(word_valid)
  );
`ifdef SWA_WORD_COUNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) word_count <= '0;
    else if (complete) word_count <= word_count + SWA_COUNT_W'(1);
`endif
endmodule

// File: tb/tb_serial_word_assembler.sv
// tb_serial_word_assembler: scoreboard bench with a bit-queue reference model
module tb_serial_word_assembler;
  localparam int W = 8;
  logic clk, rst_n, bit_in, bit_valid, bit_ready, flush, word_valid, word_ready;
  logic [W-1:0] word_out;
  logic [15:0] word_count;
  int vec = 0, miss = 0;
  serial_word_assembler #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .flush     (flush),
    .word_out  (word_out),
    .word_valid(word_valid),
    .word_ready(word_ready)
`ifdef SWA_WORD_COUNT_EN
    ,
    .word_count(word_count)
`endif
  );
`ifndef SWA_WORD_COUNT_EN
  assign word_count = '0;
`endif
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference model: accepted bits queue up; every W of them form one expected word
  logic bit_q[$];
  logic [W-1:0] exp_q[$];
  logic m_pend;
  logic [15:0] m_words;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bit_q.delete();
      exp_q.delete();
      m_pend = 0;
      m_words = 0;
    end else begin
      logic rdy;
      logic [W-1:0] w;
      rdy = !flush && !(bit_q.size() == W - 1 && m_pend && !word_ready);
      if (m_pend && word_ready) m_pend = 0;
      if (flush) bit_q.delete();
      else if (bit_valid && rdy) begin
        bit_q.push_back(bit_in);
        if (bit_q.size() == W) begin
          for (int i = 0; i < W; i++) w[i] = bit_q[i];
          bit_q.delete();
          exp_q.push_back(w);
          m_pend = 1;
          m_words = m_words + 16'd1;
        end
      end
    end
  // monitor: compares handshake and presented word away from the active edge
  always @(negedge clk) begin
    chk("bit_ready", 32'(bit_ready), 32'(!flush && !(bit_q.size() == W - 1 && m_pend && !word_ready)));
    chk("word_valid", 32'(word_valid), 32'(m_pend));
`ifdef SWA_WORD_COUNT_EN
    chk("word_count", 32'(word_count), 32'(m_words));
`endif
    if (word_valid) begin
      if (exp_q.size() == 0) chk("unexpected_word", 32'(word_out), 32'hFFFF_FFFF);
      else begin
        chk("word_out", 32'(word_out), 32'(exp_q[0]));
        if (word_ready) void'(exp_q.pop_front());
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b);
    int n = 0;
    bit_in = b;
    bit_valid = 1;
    #1;
    while (!bit_ready && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) chk("bit_accept_timeout", 0, 1);
    tick();
    bit_valid = 0;
  endtask
  task automatic send_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) send_bit(w[i]);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 0; bit_in = 0; bit_valid = 0; flush = 0; word_ready = 0;
    #12;
    chk("reset_word_valid", 32'(word_valid), 0);
    chk("reset_bit_ready", 32'(bit_ready), 1);
    chk("reset_word_out", 32'(word_out), 0);
    chk("reset_word_count", 32'(word_count), 0);
    rst_n = 1;
    tick();
    word_ready = 1;
    send_word(8'h03);
    tick();
    chk("word_03", 32'(word_out), 32'h03);
    tick();
    send_word(8'h55);
    send_word(8'hAA);
    repeat (3) tick();
    word_ready = 0;
    send_word(8'h0F);
    for (int i = 0; i < W - 1; i++) send_bit(1'(8'h3C >> i));
    bit_in = 0; bit_valid = 1;
    repeat (3) tick();
    chk("stall_ready", 32'(bit_ready), 0);
    chk("stall_hold", 32'(word_out), 32'h0F);
    word_ready = 1;
    #1;
    chk("stall_release", 32'(bit_ready), 1);
    tick();
    bit_valid = 0;
    chk("no_gap_word", 32'(word_out), 32'h3C);
    chk("no_gap_valid", 32'(word_valid), 1);
    repeat (2) tick();
    for (int i = 0; i < 5; i++) send_bit(1'(i & 1));
    flush = 1; bit_valid = 1; bit_in = 1;
    #1;
    chk("flush_ready", 32'(bit_ready), 0);
    tick();
    flush = 0; bit_valid = 0;
    send_word(8'hC0);
    tick();
    chk("flush_word", 32'(word_out), 32'hC0);
    word_ready = 0;
    send_word(8'h5A);
    for (int i = 0; i < 3; i++) send_bit(1);
    rst_n = 0;
    #1;
    chk("midreset_valid", 32'(word_valid), 0);
    chk("midreset_ready", 32'(bit_ready), 1);
    chk("midreset_out", 32'(word_out), 0);
    tick();
    rst_n = 1;
    word_ready = 1;
    send_word(8'hE7);
    tick();
    chk("clean_word", 32'(word_out), 32'hE7);
    send_word(8'h12);
    for (int i = 0; i < 3; i++) send_bit(1);
    flush = 1; tick(); flush = 0;
    send_word(8'h34);
    tick();
`ifdef SWA_WORD_COUNT_EN
    chk("count_three", 32'(word_count), 3);
`endif
    for (int c = 0; c < 2500; c++) begin
      bit_in = 1'($urandom);
      bit_valid = $urandom_range(3) != 0;
      word_ready = $urandom_range(4) > 1;
      flush = $urandom_range(39) == 0;
      tick();
    end
    bit_valid = 0; flush = 0; word_ready = 1;
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
